// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with registered one-hot grant and binary index.
// Optional GRANT_TIMEOUT_EN adds a hold counter that force-releases grants after MAX_HOLD cycles.
module rr_arbiter16
`ifdef GRANT_TIMEOUT_EN
  #(parameter logic [7:0] MAX_HOLD = 8'd64)
`endif
  (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  last;
  logic        pick_found;
  logic [3:0]  pick_idx;

`ifdef GRANT_TIMEOUT_EN
  logic [7:0]  hold_cnt;
`endif

  // Search starts just past the previous winner, so the last owner ranks lowest.
  always_comb begin
    logic [3:0] cand;
    cand       = 4'd0;
    pick_found = 1'b0;
    pick_idx   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      cand = last + 4'(k + 1);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 4'd15;
      gnt       <= 16'h0000;
      gnt_idx   <= 4'd0;
      gnt_valid <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef GRANT_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            gnt       <= 16'h0001 << pick_idx;
            gnt_idx   <= pick_idx;
            last      <= pick_idx;
            gnt_valid <= 1'b1;
            state     <= BUSY;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
          end
        end
        BUSY: begin
          // Release always passes through IDLE, giving the break-before-make bubble.
          if (!req[gnt_idx]) begin
            gnt       <= 16'h0000;
            gnt_valid <= 1'b0;
            state     <= IDLE;
`ifdef GRANT_TIMEOUT_EN
          end else if (hold_cnt == MAX_HOLD - 8'd1) begin
            gnt       <= 16'h0000;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef GRANT_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed self-checking bench for rr_arbiter16 (vector table plus hand-written corner sequences).
module tb_rr_arbiter16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] req;
    logic        en;
    logic [15:0] gnt;
    logic [3:0]  idx;
  } vec_t;

  vec_t vecs[$];

`ifdef GRANT_TIMEOUT_EN
  rr_arbiter16 #(.MAX_HOLD(8'd4)) dut (
`else
  rr_arbiter16 dut (
`endif
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [15:0] exp_gnt,
                              input logic [3:0] exp_idx, input logic exp_to);
    check_value({name, ".gnt"}, gnt, exp_gnt);
    check_value({name, ".gnt_idx"}, 16'(gnt_idx), 16'(exp_idx));
    check_value({name, ".gnt_valid"}, 16'(gnt_valid), 16'(exp_gnt != 16'h0000));
    check_value({name, ".timeout"}, 16'(timeout), 16'(exp_to));
  endtask

  task automatic apply_stimulus(input logic [15:0] r, input logic e);
    req = r;
    en  = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] r);
    apply_stimulus(r, 1'b1);
    rst_n = 1'b0;
    #2;
    check_output("reset", 16'h0000, 4'd0, 1'b0);
    step();
    check_output("reset_edge", 16'h0000, 4'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    apply_stimulus(16'h0000, 1'b1);
    #3;

    // Reset with all requesters active, requester 0 wins first.
    do_reset(16'hFFFF);
    step();
    check_output("first_grant", 16'h0001, 4'd0, 1'b0);

    // Rotation 0,5,10,15,0 with one bubble between grants.
    vecs.push_back('{16'h8421, 1'b1, 16'h0001, 4'd0});
    vecs.push_back('{16'h8421, 1'b1, 16'h0001, 4'd0});
    vecs.push_back('{16'h8420, 1'b1, 16'h0000, 4'd0});
    vecs.push_back('{16'h8421, 1'b1, 16'h0020, 4'd5});
    vecs.push_back('{16'h8421, 1'b1, 16'h0020, 4'd5});
    vecs.push_back('{16'h8401, 1'b1, 16'h0000, 4'd5});
    vecs.push_back('{16'h8421, 1'b1, 16'h0400, 4'd10});
    vecs.push_back('{16'h8421, 1'b1, 16'h0400, 4'd10});
    vecs.push_back('{16'h8021, 1'b1, 16'h0000, 4'd10});
    vecs.push_back('{16'h8421, 1'b1, 16'h8000, 4'd15});
    vecs.push_back('{16'h8421, 1'b1, 16'h8000, 4'd15});
    vecs.push_back('{16'h0421, 1'b1, 16'h0000, 4'd15});
    vecs.push_back('{16'h8421, 1'b1, 16'h0001, 4'd0});
    vecs.push_back('{16'h0000, 1'b1, 16'h0000, 4'd0});
    // Enable gating: en low blocks new grants but not a held one.
    vecs.push_back('{16'h0010, 1'b0, 16'h0000, 4'd0});
    vecs.push_back('{16'h0010, 1'b0, 16'h0000, 4'd0});
    vecs.push_back('{16'h0010, 1'b0, 16'h0000, 4'd0});
    vecs.push_back('{16'h0010, 1'b0, 16'h0000, 4'd0});
    vecs.push_back('{16'h0010, 1'b0, 16'h0000, 4'd0});
    vecs.push_back('{16'h0010, 1'b1, 16'h0010, 4'd4});
    vecs.push_back('{16'h0010, 1'b0, 16'h0010, 4'd4});
    vecs.push_back('{16'h0011, 1'b0, 16'h0010, 4'd4});
    vecs.push_back('{16'h0001, 1'b0, 16'h0000, 4'd4});
    vecs.push_back('{16'h0001, 1'b0, 16'h0000, 4'd4});

    do_reset(16'h0000);
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].req, vecs[i].en);
      step();
      check_output($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, 1'b0);
    end

    // Sole requester 0 from last=15 is re-granted every two cycles.
    do_reset(16'h0000);
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(16'h0001, 1'b1);
      step();
      check_output($sformatf("sole_gnt%0d", p), 16'h0001, 4'd0, 1'b0);
      apply_stimulus(16'h0000, 1'b1);
      step();
      check_output($sformatf("sole_rel%0d", p), 16'h0000, 4'd0, 1'b0);
    end

    // Async reset mid-grant clears outputs without a clock edge and restores last=15.
    do_reset(16'h0000);
    apply_stimulus(16'h0200, 1'b1);
    step();
    check_output("pre_async", 16'h0200, 4'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_clear", 16'h0000, 4'd0, 1'b0);
    apply_stimulus(16'h0401, 1'b1);
    #1;
    rst_n = 1'b1;
    step();
    check_output("post_async", 16'h0001, 4'd0, 1'b0);

`ifdef GRANT_TIMEOUT_EN
    // MAX_HOLD=4: four cycles of ownership, timeout pulse, bubble, then requester 1.
    do_reset(16'h0000);
    apply_stimulus(16'h0003, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      check_output($sformatf("to_hold%0d", c), 16'h0001, 4'd0, 1'b0);
    end
    step();
    check_output("to_release", 16'h0000, 4'd0, 1'b1);
    step();
    check_output("to_next", 16'h0002, 4'd1, 1'b0);
`else
    // Without the timeout feature a grant is held indefinitely.
    do_reset(16'h0000);
    apply_stimulus(16'h0003, 1'b1);
    for (int c = 0; c < 70; c++) step();
    check_output("long_hold", 16'h0001, 4'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
